// File: rtl/demux_4by64_buf.sv
// Registered 1-to-4 router: one producer stream steered by in_sel into four
// single-entry holding registers, each with its own valid/ready handshake.
module demux_4by64_buf #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic               busy
);

   logic push;

   // A full port still accepts when its consumer drains the old word this cycle.
   assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
   assign push     = in_valid && in_ready;
   assign busy     = |out_valid;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_port
         logic             v_reg;
         logic             v_next;
         logic [WIDTH-1:0] d_reg;
         logic [WIDTH-1:0] d_next;
         logic             push_hit;

         assign push_hit = push && (in_sel == 2'(gi));

         always_comb begin
            v_next = v_reg;
            d_next = d_reg;
            if (push_hit) begin
               v_next = 1'b1;
               d_next = in_data;
            end else if (v_reg && out_ready[gi]) begin
               v_next = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_reg <= 1'b0;
               d_reg <= '0;
            end else begin
               v_reg <= v_next;
               d_reg <= d_next;
            end
         end

         assign out_valid[gi]              = v_reg;
         assign out_data[gi*WIDTH +: WIDTH] = d_reg;
      end
   endgenerate

endmodule

// File: tb/tb_demux_4by64_buf.sv
// Directed and randomized checks of the 4-way 64-bit router against
// hand-computed values and a per-port queue scoreboard.
module tb_demux_4by64_buf;

   localparam int WIDTH = 64;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_sel;
   logic               in_valid;
   logic               in_ready;
   logic [4*WIDTH-1:0] out_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic               busy;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] q [4][$];

   demux_4by64_buf #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] slice(input int i);
      return out_data[i*WIDTH +: WIDTH];
   endfunction

   initial begin
      logic [WIDTH-1:0] w;
      logic             exp_rdy;
      logic [3:0]       exp_v;
      int               pops;

      // Reset with active handshake stimulus applied
      rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = 64'h1111_2222_3333_4444;
      out_ready = 4'hF;
      tick(); tick();
      chk("rst_out_valid", 256'(out_valid), 256'h0);
      chk("rst_out_data",  out_data, 256'h0);
      chk("rst_busy",      256'(busy), 256'h0);
      chk("rst_in_ready",  256'(in_ready), 256'h1);
      $display("txn reset done");

      // Release: held push lands only at the first edge with rst_n=1
      rst_n = 1'b1; out_ready = 4'h0; in_data = 64'hAA;
      @(negedge clk);
      chk("release_no_load", 256'(out_valid), 256'h0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("release_load_v", 256'(out_valid), 256'h1);
      chk("release_load_d", 256'(slice(0)), 256'hAA);
      out_ready = 4'h1; tick(); out_ready = 4'h0;
      chk("release_drain", 256'(out_valid), 256'h0);
      $display("txn release push AA to port0 and drain");

      // Single route to port 2
      in_data = 64'hDEAD_BEEF_0123_4567; in_sel = 2'd2; in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      chk("single_v",    256'(out_valid), 256'h4);
      chk("single_d",    256'(slice(2)), 256'hDEAD_BEEF_0123_4567);
      chk("single_busy", 256'(busy), 256'h1);
      out_ready = 4'h4; tick(); out_ready = 4'h0;
      chk("single_pop", 256'(out_valid), 256'h0);
      chk("single_pop_busy", 256'(busy), 256'h0);
      $display("txn single route port2");

      // Backpressure on port 1, then redirect to port 3
      in_data = 64'h0000_0000_0000_0B01; in_sel = 2'd1; in_valid = 1'b1;
      tick();
      in_data = 64'h0000_0000_0000_0B02;
      for (int k = 0; k < 5; k++) begin
         chk("bp_in_ready", 256'(in_ready), 256'h0);
         tick();
         chk("bp_hold", 256'(slice(1)), 256'h0B01);
      end
      in_sel = 2'd3;
      #1;
      chk("bp_redirect_ready", 256'(in_ready), 256'h1);
      tick(); in_valid = 1'b0;
      chk("bp_redirect_v", 256'(out_valid), 256'hA);
      chk("bp_redirect_d", 256'(slice(3)), 256'h0B02);
      chk("bp_port1_kept", 256'(slice(1)), 256'h0B01);
      out_ready = 4'hF; tick(); out_ready = 4'h0;
      chk("bp_drain", 256'(out_valid), 256'h0);
      $display("txn backpressure port1, redirect port3");

      // Streaming into port 0 with the consumer always ready
      out_ready = 4'h1; in_sel = 2'd0; in_valid = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_data = 64'(k);
         #1;
         chk("stream_ready", 256'(in_ready), 256'h1);
         tick();
         chk("stream_v", 256'(out_valid[0]), 256'h1);
         chk("stream_d", 256'(slice(0)), 256'(k));
         $display("txn stream word %0d on port0", k);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_end", 256'(out_valid), 256'h0);
      out_ready = 4'h0;

      // Simultaneous pop and push on port 0
      in_data = 64'hA; in_sel = 2'd0; in_valid = 1'b1;
      tick();
      in_data = 64'hB; out_ready = 4'h1;
      tick();
      chk("simul_same_v", 256'(out_valid), 256'h1);
      chk("simul_same_d", 256'(slice(0)), 256'hB);
      // Pop port 0 while loading port 3
      in_data = 64'hC; in_sel = 2'd3;
      tick();
      chk("simul_x_v0", 256'(out_valid), 256'h8);
      // Pop port 3 while loading port 1
      in_data = 64'hD; in_sel = 2'd1; out_ready = 4'h8;
      tick();
      in_valid = 1'b0; out_ready = 4'h0;
      chk("simul_x_v1", 256'(out_valid), 256'h2);
      chk("simul_x_d1", 256'(slice(1)), 256'hD);
      out_ready = 4'hF; tick(); out_ready = 4'h0;
      chk("simul_drain", 256'(out_valid), 256'h0);
      $display("txn simultaneous push/pop cases");

      // Random traffic checked against per-port queues
      pops = 0;
      for (int c = 0; c < 2000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = {$urandom, $urandom};
         out_ready = 4'($urandom_range(0, 15));
         #1;
         exp_rdy = (q[in_sel].size() == 0) || out_ready[in_sel];
         for (int i = 0; i < 4; i++) exp_v[i] = (q[i].size() != 0);
         chk("rnd_in_ready", 256'(in_ready), 256'(exp_rdy));
         chk("rnd_out_valid", 256'(out_valid), 256'(exp_v));
         chk("rnd_busy", 256'(busy), 256'(|exp_v));
         for (int i = 0; i < 4; i++) begin
            if (exp_v[i] && out_ready[i]) begin
               w = q[i].pop_front();
               chk("rnd_data", 256'(slice(i)), 256'(w));
               pops++;
               $display("txn rnd cycle %0d port%0d delivered %h", c, i, w);
            end
         end
         if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
         tick();
      end
      $display("txn random done, %0d words delivered", pops);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
